// File: rtl/mem_port.sv
// Byte-wide memory port: turns one execute-stage load/store request into one
// or two 8-bit bus beats, stalling the pipeline until the access completes.
module mem_port #(
   parameter logic [15:0] MAR_RESET = 16'h0000
) (
   input  logic        clk,
   input  logic        a_rst,
   input  logic        mar_wr,
   input  logic [15:0] addr_in,
   input  logic        mem_rq,
   input  logic        mem_rq_cmd,
   input  logic        mem_rq_width,
   input  logic [15:0] wr_data,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_dout,
   input  logic [7:0]  bus_din,
   output logic        bus_req,
   output logic        bus_we,
   input  logic        bus_ack,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   output logic        stop
);

   typedef enum logic [1:0] {IDLE, LO, HI} state_t;

   state_t      state_q;
   logic [15:0] mar_q;
   logic [15:0] bus_addr_q;
   logic [7:0]  bus_dout_q;
   logic        bus_req_q;
   logic        bus_we_q;
   logic        width_q;
   logic [7:0]  hi_byte_q;
   logic [7:0]  lo_q;
   logic [15:0] rd_data_q;
   logic        rd_valid_q;
   logic [15:0] addr_d;

   // A request issued together with mar_wr uses the new address directly.
   assign addr_d = mar_wr ? addr_in : mar_q;

   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         state_q    <= IDLE;
         mar_q      <= MAR_RESET;
         bus_addr_q <= 16'h0000;
         bus_dout_q <= 8'h00;
         bus_req_q  <= 1'b0;
         bus_we_q   <= 1'b0;
         width_q    <= 1'b0;
         hi_byte_q  <= 8'h00;
         lo_q       <= 8'h00;
         rd_data_q  <= 16'h0000;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (mar_wr)
                  mar_q <= addr_in;
               if (mem_rq) begin
                  state_q    <= LO;
                  bus_req_q  <= 1'b1;
                  bus_we_q   <= mem_rq_cmd;
                  bus_addr_q <= addr_d;
                  bus_dout_q <= wr_data[7:0];
                  hi_byte_q  <= wr_data[15:8];
                  width_q    <= mem_rq_width;
               end
            end
            LO: begin
               if (bus_ack) begin
                  if (!bus_we_q)
                     lo_q <= bus_din;
                  if (width_q) begin
                     state_q    <= HI;
                     bus_addr_q <= bus_addr_q + 16'd1;
                     bus_dout_q <= hi_byte_q;
                  end else begin
                     state_q    <= IDLE;
                     bus_req_q  <= 1'b0;
                     bus_we_q   <= 1'b0;
                     bus_addr_q <= 16'h0000;
                     bus_dout_q <= 8'h00;
                     if (!bus_we_q) begin
                        rd_data_q  <= {8'h00, bus_din};
                        rd_valid_q <= 1'b1;
                     end
                  end
               end
            end
            HI: begin
               if (bus_ack) begin
                  state_q    <= IDLE;
                  bus_req_q  <= 1'b0;
                  bus_we_q   <= 1'b0;
                  bus_addr_q <= 16'h0000;
                  bus_dout_q <= 8'h00;
                  if (!bus_we_q) begin
                     rd_data_q  <= {bus_din, lo_q};
                     rd_valid_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stop     = (state_q != IDLE);
   assign bus_req  = bus_req_q;
   assign bus_we   = bus_we_q;
   assign bus_addr = bus_addr_q;
   assign bus_dout = bus_dout_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_mem_port.sv
// Directed plus randomized bench for mem_port against a byte-addressed memory
// model; every transaction is checked beat by beat.
module tb_mem_port;

   localparam logic [15:0] MAR_R = 16'h4A5C;

   logic        clk;
   logic        a_rst;
   logic        mar_wr;
   logic [15:0] addr_in;
   logic        mem_rq;
   logic        mem_rq_cmd;
   logic        mem_rq_width;
   logic [15:0] wr_data;
   logic [15:0] bus_addr;
   logic [7:0]  bus_dout;
   logic [7:0]  bus_din;
   logic        bus_req;
   logic        bus_we;
   logic        bus_ack;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        stop;

   mem_port #(.MAR_RESET(MAR_R)) dut (
      .clk          (clk),
      .a_rst        (a_rst),
      .mar_wr       (mar_wr),
      .addr_in      (addr_in),
      .mem_rq       (mem_rq),
      .mem_rq_cmd   (mem_rq_cmd),
      .mem_rq_width (mem_rq_width),
      .wr_data      (wr_data),
      .bus_addr     (bus_addr),
      .bus_dout     (bus_dout),
      .bus_din      (bus_din),
      .bus_req      (bus_req),
      .bus_we       (bus_we),
      .bus_ack      (bus_ack),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .stop         (stop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks;
   int          errors;
   logic [7:0]  mem_m [0:65535];
   logic [15:0] mar_m;
   logic [15:0] last_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         mem_rq  = 1'b0;
         mar_wr  = 1'b0;
         bus_ack = ($urandom_range(0, 1) != 0);
         bus_din = 8'($urandom);
         step();
         chk("idle_stop", stop, 1'b0);
         chk("idle_bus_req", bus_req, 1'b0);
         chk("idle_rd_valid", rd_valid, 1'b0);
         chk("idle_rd_data", rd_data, last_rd);
      end
      bus_ack = 1'b0;
   endtask

   task automatic mar_load(input logic [15:0] a);
      mem_rq  = 1'b0;
      mar_wr  = 1'b1;
      addr_in = a;
      step();
      mar_wr  = 1'b0;
      mar_m   = a;
      chk("marld_stop", stop, 1'b0);
   endtask

   task automatic access(input bit cmd, input bit wid, input bit fwd,
                         input logic [15:0] a_in, input logic [15:0] wd, input int waits);
      logic [15:0] a;
      logic [15:0] a1;
      logic [15:0] ba;
      logic [15:0] exp_rd;
      logic [7:0]  byte_w;
      int          nb;
      a      = fwd ? a_in : mar_m;
      if (fwd) mar_m = a_in;
      a1     = a + 16'd1;
      nb     = wid ? 2 : 1;
      exp_rd = wid ? {mem_m[a1], mem_m[a]} : {8'h00, mem_m[a]};

      mar_wr       = fwd;
      addr_in      = a_in;
      mem_rq       = 1'b1;
      mem_rq_cmd   = cmd;
      mem_rq_width = wid;
      wr_data      = wd;
      step();
      // Scramble the request inputs and try to move MAR while busy.
      mem_rq       = 1'b0;
      mem_rq_cmd   = ($urandom_range(0, 1) != 0);
      mem_rq_width = ($urandom_range(0, 1) != 0);
      wr_data      = 16'($urandom);
      mar_wr       = 1'b1;
      addr_in      = 16'($urandom);

      for (int b = 0; b < nb; b++) begin
         ba     = (b == 0) ? a : a1;
         byte_w = (b == 0) ? wd[7:0] : wd[15:8];
         for (int w = 0; w <= waits; w++) begin
            chk("busy_stop", stop, 1'b1);
            chk("busy_bus_req", bus_req, 1'b1);
            chk("busy_bus_addr", bus_addr, ba);
            chk("busy_bus_we", bus_we, cmd);
            chk("busy_bus_dout", bus_dout, byte_w);
            chk("busy_rd_hold", rd_data, last_rd);
            chk("busy_rd_valid", rd_valid, 1'b0);
            bus_ack = (w == waits);
            bus_din = (w == waits && !cmd) ? mem_m[ba] : 8'($urandom);
            step();
         end
         if (cmd) mem_m[ba] = byte_w;
      end
      bus_ack = 1'b0;
      mar_wr  = 1'b0;
      bus_din = 8'($urandom);

      chk("done_stop", stop, 1'b0);
      chk("done_bus_req", bus_req, 1'b0);
      chk("done_rd_valid", rd_valid, !cmd);
      if (!cmd) last_rd = exp_rd;
      chk("done_rd_data", rd_data, last_rd);
      $display("txn %s %s addr=%h waits=%0d wdata=%h rd_data=%h",
               cmd ? "write" : "read", wid ? "word" : "byte", a, waits, wd, rd_data);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      last_rd      = 16'h0000;
      a_rst        = 1'b0;
      mar_wr       = 1'b0;
      addr_in      = 16'h0000;
      mem_rq       = 1'b0;
      mem_rq_cmd   = 1'b0;
      mem_rq_width = 1'b0;
      wr_data      = 16'h0000;
      bus_din      = 8'h00;
      bus_ack      = 1'b0;
      for (int i = 0; i < 65536; i++) mem_m[i] = 8'($urandom);

      step();
      step();
      chk("rst_stop", stop, 1'b0);
      chk("rst_bus_req", bus_req, 1'b0);
      chk("rst_bus_we", bus_we, 1'b0);
      chk("rst_bus_addr", bus_addr, 16'h0000);
      chk("rst_bus_dout", bus_dout, 8'h00);
      chk("rst_rd_data", rd_data, 16'h0000);
      chk("rst_rd_valid", rd_valid, 1'b0);
      a_rst = 1'b1;
      mar_m = MAR_R;

      // Spurious acks while idle.
      idle(4);

      // Byte read through MAR.
      mem_m[16'h1234] = 8'hA5;
      mar_load(16'h1234);
      access(1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 0);

      // Word write with forwarded address and two wait states per beat.
      access(1'b1, 1'b1, 1'b1, 16'h2000, 16'hBEEF, 2);
      idle(1);

      // Word read wrapping past 16'hFFFF.
      mem_m[16'hFFFF] = 8'h34;
      mem_m[16'h0000] = 8'h12;
      mar_load(16'hFFFF);
      access(1'b0, 1'b1, 1'b0, 16'($urandom), 16'($urandom), 0);
      chk("wrap_rd_data", rd_data, 16'h1234);

      // Back-to-back reads.
      access(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0000, 0);
      access(1'b0, 1'b1, 1'b0, 16'($urandom), 16'h0000, 1);

      // Reset during the high beat of a word read.
      mar_wr       = 1'b0;
      mem_rq       = 1'b1;
      mem_rq_cmd   = 1'b0;
      mem_rq_width = 1'b1;
      step();
      mem_rq  = 1'b0;
      bus_ack = 1'b1;
      bus_din = 8'($urandom);
      step();
      bus_ack = 1'b0;
      chk("midrst_pre_bus_req", bus_req, 1'b1);
      a_rst = 1'b0;
      #1;
      chk("midrst_bus_req", bus_req, 1'b0);
      chk("midrst_stop", stop, 1'b0);
      chk("midrst_bus_addr", bus_addr, 16'h0000);
      chk("midrst_rd_data", rd_data, 16'h0000);
      chk("midrst_rd_valid", rd_valid, 1'b0);
      step();
      a_rst   = 1'b1;
      mar_m   = MAR_R;
      last_rd = 16'h0000;
      idle(3);
      access(1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 0);

      // Randomized traffic, gaps of zero give back-to-back requests.
      for (int t = 0; t < 60; t++) begin
         int gap;
         gap = $urandom_range(0, 2);
         if (gap != 0) idle(gap);
         if ($urandom_range(0, 3) == 0) mar_load(16'($urandom));
         access($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                $urandom_range(0, 1) != 0, 16'($urandom), 16'($urandom),
                $urandom_range(0, 3));
      end
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port.md
MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001 SHALL have parameter MAR_RESET, default 16'h0000, the MAR value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the system clock; all state updates on its rising edge.
REQ-003 SHALL have port a_rst, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port mar_wr, input, 1, load MAR from addr_in.
REQ-005 SHALL have port addr_in, input, 16, the memory address from the execute datapath.
REQ-006 SHALL have port mem_rq, input, 1, the memory request strobe from execute.
REQ-007 SHALL have port mem_rq_cmd, input, 1, the access type: 1 = write, 0 = read.
REQ-008 SHALL have port mem_rq_width, input, 1, the access width: 1 = 16-bit word, 0 = byte.
REQ-009 SHALL have port wr_data, input, 16, the store data.
REQ-010 SHALL have port bus_addr, output, 16, the external byte address.
REQ-011 SHALL have port bus_dout, output, 8, the external write byte.
REQ-012 SHALL have port bus_din, input, 8, the external read byte.
REQ-013 SHALL have port bus_req, output, 1, the bus cycle request.
REQ-014 SHALL have port bus_we, output, 1, the bus write enable.
REQ-015 SHALL have port bus_ack, input, 1, the bus beat completion.
REQ-016 SHALL have port rd_data, output, 16, the load result.
REQ-017 SHALL have port rd_valid, output, 1, a one-cycle pulse meaning rd_data is valid.
REQ-018 SHALL have port stop, output, 1, the pipeline stall to execute and scheduler.

Function
REQ-019 SHALL use states IDLE, LO, HI; all outputs SHALL be registered or decoded from registered state only, with no combinational path from any input to stop, bus_req, bus_we, bus_addr or bus_dout.
REQ-020 SHALL, in IDLE, load MAR <= addr_in when mar_wr=1; mar_wr in LO/HI SHALL be ignored.
REQ-021 SHALL, in IDLE with mem_rq=1: latch cmd, width and wr_data; take the address from addr_in if mar_wr=1 in the same cycle (forwarding), else from MAR; go to LO.
REQ-022 SHALL drive stop = (state != IDLE).
REQ-023 SHALL, in LO: bus_req=1, bus_addr=address, bus_we=cmd, bus_dout=wr_data[7:0].
REQ-024 SHALL, in HI: bus_req=1, bus_addr=address+1 modulo 2^16 (16'hFFFF wraps to 16'h0000), bus_we=cmd, bus_dout=wr_data[15:8].
REQ-025 SHALL hold bus_req, bus_addr, bus_we and bus_dout stable while in a state until bus_ack=1 is sampled; there is no limit on wait states.
REQ-026 SHALL, on LO with bus_ack=1: capture bus_din into the low byte on a read; go to HI if width=1, else go to IDLE.
REQ-027 SHALL, on HI with bus_ack=1: capture bus_din into the high byte on a read; go to IDLE.
REQ-028 SHALL pulse rd_valid for exactly one cycle, the first IDLE cycle after a completed read; byte reads SHALL return {8'h00, lo}, word reads {hi, lo}.
REQ-029 SHALL hold rd_data at the last load result until the next read completes; writes SHALL neither pulse rd_valid nor change rd_data.
REQ-030 SHALL ignore bus_ack whenever bus_req=0.
REQ-031 SHALL, with zero wait states, give: byte access stop high 1 cycle, result at request+2; word access stop high 2 cycles, result at request+3.
REQ-032 SHALL accept a new mem_rq in the same IDLE cycle in which rd_valid pulses (back-to-back).
REQ-033 SHALL leave MAR unchanged by accesses; MAR changes only via mar_wr or reset.

Reset
REQ-034 SHALL, while a_rst=0 (immediately, asynchronously): state=IDLE, MAR=MAR_RESET, stop=0, bus_req=0, bus_we=0, bus_addr=0, bus_dout=0, rd_data=0, rd_valid=0.
REQ-035 SHALL abandon an in-flight beat on reset mid-transaction, with no rd_valid pulse afterwards.

Verification
REQ-036 SHALL cover a byte read: mar_wr with addr_in=16'h1234, then mem_rq read byte, bus_din=8'hA5, ack same cycle -> bus_addr=16'h1234, stop for 1 cycle, rd_data=16'h00A5, rd_valid at request+2.
REQ-037 SHALL cover a word write: mar_wr and mem_rq in the same cycle, addr_in=16'h2000, wr_data=16'hBEEF, 2 wait states per beat -> beat 1 addr 2000/dout EF, beat 2 addr 2001/dout BE, bus_we=1, stop for 6 cycles, no rd_valid.
REQ-038 SHALL cover a word read at 16'hFFFF: bytes 34 then 12 -> second beat addr 16'h0000, rd_data=16'h1234.
REQ-039 SHALL cover back-to-back reads: a second mem_rq in the rd_valid cycle -> bus_req reasserts the next cycle, and the first rd_data holds until the second completes.
REQ-040 SHALL cover reset mid-operation: a_rst low during HI of a word read -> bus_req and stop fall immediately; after release IDLE with MAR=MAR_RESET and no rd_valid.
REQ-041 SHALL cover a spurious ack: bus_ack=1 in IDLE -> no state change, no rd_valid.
